trace_dispatch: RTL and testbench
=================================

Name: trace_dispatch

Overview:
- Sits directly downstream of the trace-file reader.
- Accepts one (op, address) trace command per valid/ready handshake and buffers up to 2 commands.
- Decodes the 4-bit op, splits the 32-bit address into tag/index/offset, and issues each command by req/ack handshake to the L1 data cache, the L1 instruction cache, or both.
- Drops illegal ops and keeps dispatch and error counters for the statistics printout.

Parameters:
- ADDR_W, 32, trace address width
- OFFSET_W, 6, byte-offset bits (64-byte line)
- DC_INDEX_W, 14, data-cache set index bits
- IC_INDEX_W, 14, instruction-cache set index bits
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream command valid
- in_ready  out  1  FIFO can accept (= not full)
- in_op  in  4  trace op code
- in_addr  in  ADDR_W  trace address
- dc_req  out  1  data-cache request
- dc_ack  in  1  data-cache accepted current request
- dc_op  out  4  op forwarded
- dc_tag  out  ADDR_W-DC_INDEX_W-OFFSET_W  tag field
- dc_index  out  DC_INDEX_W  set index
- dc_offset  out  OFFSET_W  byte offset
- ic_req, ic_ack, ic_op, ic_tag, ic_index, ic_offset  same as dc_*, using IC_INDEX_W
- n_dispatched  out  CNT_W  completed legal commands
- n_bad_op  out  CNT_W  dropped illegal commands

Behaviour:
- Reset (async assert, sync release) clears:
  - all outputs, with in_ready=1
  - FIFO empty, state IDLE, both counters 0
- FIFO: 2 entries; push on in_valid&&in_ready; pop on command completion. Push and pop in the same cycle are legal when full; in_ready depends on registered fullness only.
- Routing, from the FIFO head op:
  - 0 read, 1 write → data cache only
  - 2 fetch → instruction cache only
  - 3 invalidate, 4 snoop, 8 clear, 9 print → both caches (broadcast)
  - 5-7, 10-15 → illegal
- Address split: offset=addr[OFFSET_W-1:0]; index=next INDEX_W bits; tag=remaining upper bits. Computed per cache from the head entry.
- State machine:
  - IDLE: FIFO empty → stay. Head illegal → pop, n_bad_op+1, stay IDLE, no req. Head legal → ISSUE next cycle, clear done flags dc_done/ic_done.
  - ISSUE: assert X_req for each targeted cache whose done flag is 0. Fields and op stay stable while req is high. An X_ack while X_req is high sets X_done.
  - Completion: all targeted caches acked (acks may arrive in the same or different cycles) → that cycle pop, n_dispatched+1, go IDLE. req drops the following cycle.
- Latency and gaps:
  - Entry pushed in cycle N → earliest req in cycle N+2 (N+1 IDLE sees head, N+2 ISSUE).
  - Minimum one req-low cycle between commands.
- Ack without req is ignored. Ack sampled combinationally in the ISSUE cycle, so a zero-wait cache completes in one ISSUE cycle.
- Op 8: on completion both counters clear to 0; clear wins over the n_dispatched increment for op 8 itself.
- Counters saturate at all-ones; no wrap.
- Reset mid-ISSUE: req drops immediately (async), in-flight and buffered commands are discarded.

Decomposition:
- Shared package cache_pkg holds:
  - op-code constants OP_READ=0, OP_WRITE=1, OP_FETCH=2, OP_INVAL=3, OP_SNOOP=4, OP_CLEAR=8, OP_PRINT=9
  - the route enum {RT_NONE, RT_DC, RT_IC, RT_BOTH}
  - the state enum
- One sub-module, trace_fifo: 2-deep, parameterised width, push/pop/full/empty.

Test Plan:
- Op 0, addr 0x12345678, dc_ack returned 2 cycles after dc_req rises → dc_tag=0x123, dc_index=0x1159, dc_offset=0x38, dc_op=0, ic_req never high, n_dispatched=1.
- Op 2, addr 0x0000_0040, ic_ack held high → ic_req high exactly 1 cycle, ic_index=0x0001, ic_offset=0, n_dispatched=1.
- Op 3 broadcast, dc_ack at cycle +1, ic_ack at cycle +4 → dc_req drops after cycle +1, ic_req held through +4, single pop, n_dispatched=1.
- Op 6 then op 1 back-to-back → no req for op 6, n_bad_op=1, op 1 dispatched to dc, n_dispatched=1.
- Three pushes with acks withheld → in_ready=0 after 2 accepted; third accepted the cycle after first completion; order preserved.
- After 5 dispatches, issue op 8 with both acks → n_dispatched=0, n_bad_op=0; then assert rst_n=0 during an ISSUE → dc_req/ic_req low immediately, FIFO empty, in_ready=1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the trace dispatcher: op codes, cache routing and FSM states.
package cache_pkg;

    localparam logic [3:0] OP_READ  = 4'd0;
    localparam logic [3:0] OP_WRITE = 4'd1;
    localparam logic [3:0] OP_FETCH = 4'd2;
    localparam logic [3:0] OP_INVAL = 4'd3;
    localparam logic [3:0] OP_SNOOP = 4'd4;
    localparam logic [3:0] OP_CLEAR = 4'd8;
    localparam logic [3:0] OP_PRINT = 4'd9;

    typedef enum logic [1:0] {RT_NONE, RT_DC, RT_IC, RT_BOTH} route_t;

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    // Which cache(s) an op targets; RT_NONE marks an illegal op.
    function automatic route_t route_of(input logic [3:0] op);
        route_t rt;
        case (op)
            OP_READ, OP_WRITE:                     rt = RT_DC;
            OP_FETCH:                              rt = RT_IC;
            OP_INVAL, OP_SNOOP, OP_CLEAR, OP_PRINT: rt = RT_BOTH;
            default:                               rt = RT_NONE;
        endcase
        return rt;
    endfunction

endpackage

// File: rtl/trace_dispatch_if.sv
// Trace-command input and the two cache request channels of the dispatcher.
interface trace_dispatch_if #(
    parameter int ADDR_W     = 32,
    parameter int OFFSET_W   = 6,
    parameter int DC_INDEX_W = 14,
    parameter int IC_INDEX_W = 14
);
    logic                                  in_valid;
    logic                                  in_ready;
    logic [3:0]                            in_op;
    logic [ADDR_W-1:0]                     in_addr;

    logic                                  dc_req;
    logic                                  dc_ack;
    logic [3:0]                            dc_op;
    logic [ADDR_W-DC_INDEX_W-OFFSET_W-1:0] dc_tag;
    logic [DC_INDEX_W-1:0]                 dc_index;
    logic [OFFSET_W-1:0]                   dc_offset;

    logic                                  ic_req;
    logic                                  ic_ack;
    logic [3:0]                            ic_op;
    logic [ADDR_W-IC_INDEX_W-OFFSET_W-1:0] ic_tag;
    logic [IC_INDEX_W-1:0]                 ic_index;
    logic [OFFSET_W-1:0]                   ic_offset;

    // Dispatcher side
    modport master (
        input  in_valid, in_op, in_addr, dc_ack, ic_ack,
        output in_ready,
        output dc_req, dc_op, dc_tag, dc_index, dc_offset,
        output ic_req, ic_op, ic_tag, ic_index, ic_offset
    );

    // Trace reader + caches side
    modport slave (
        output in_valid, in_op, in_addr, dc_ack, ic_ack,
        input  in_ready,
        input  dc_req, dc_op, dc_tag, dc_index, dc_offset,
        input  ic_req, ic_op, ic_tag, ic_index, ic_offset
    );

endinterface

// File: rtl/trace_fifo.sv
// Two-entry command buffer between the trace reader and the dispatch FSM.
module trace_fifo #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rptr];

    // Storage: data only, never reset
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_push) r_wptr <= ~r_wptr;
            if (w_do_pop)  r_rptr <= ~r_rptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/trace_dispatch.sv
// Buffers trace commands, decodes op/address and issues them to the L1 D/I caches.
module trace_dispatch
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int OFFSET_W   = 6,
    parameter int DC_INDEX_W = 14,
    parameter int IC_INDEX_W = 14,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    trace_dispatch_if.master  bus,
    output logic [CNT_W-1:0]  n_dispatched,
    output logic [CNT_W-1:0]  n_bad_op
);
    localparam int FW   = 4 + ADDR_W;
    localparam int DT_W = ADDR_W - DC_INDEX_W - OFFSET_W;
    localparam int IT_W = ADDR_W - IC_INDEX_W - OFFSET_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [FW-1:0]     w_head;
    logic [3:0]        w_head_op;
    logic [ADDR_W-1:0] w_head_addr;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    route_t            w_route;
    logic              w_dc_ok;
    logic              w_ic_ok;
    logic              w_complete;

    state_t                r_state;
    logic                  r_dc_req, r_ic_req;
    logic                  r_dc_done, r_ic_done;
    logic                  r_tgt_dc, r_tgt_ic;
    logic [3:0]            r_op;
    logic [DT_W-1:0]       r_dc_tag;
    logic [DC_INDEX_W-1:0] r_dc_index;
    logic [IT_W-1:0]       r_ic_tag;
    logic [IC_INDEX_W-1:0] r_ic_index;
    logic [OFFSET_W-1:0]   r_offset;
    logic [CNT_W-1:0]      r_n_disp;
    logic [CNT_W-1:0]      r_n_bad;

    assign w_push       = bus.in_valid && !w_full;
    assign bus.in_ready = !w_full;

    trace_fifo #(.W(FW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({bus.in_op, bus.in_addr}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_op   = w_head[FW-1 -: 4];
    assign w_head_addr = w_head[ADDR_W-1:0];
    assign w_route     = route_of(w_head_op);

    // A cache is satisfied if untargeted, already acked, or acking right now
    assign w_dc_ok    = !r_tgt_dc || r_dc_done || (r_dc_req && bus.dc_ack);
    assign w_ic_ok    = !r_tgt_ic || r_ic_done || (r_ic_req && bus.ic_ack);
    assign w_complete = (r_state == ST_ISSUE) && w_dc_ok && w_ic_ok;
    assign w_pop      = ((r_state == ST_IDLE) && !w_empty && (w_route == RT_NONE)) || w_complete;

    // Dispatch FSM with registered request/field outputs and statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_dc_req   <= 1'b0;
            r_ic_req   <= 1'b0;
            r_dc_done  <= 1'b0;
            r_ic_done  <= 1'b0;
            r_tgt_dc   <= 1'b0;
            r_tgt_ic   <= 1'b0;
            r_op       <= '0;
            r_dc_tag   <= '0;
            r_dc_index <= '0;
            r_ic_tag   <= '0;
            r_ic_index <= '0;
            r_offset   <= '0;
            r_n_disp   <= '0;
            r_n_bad    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (w_route == RT_NONE) begin
                            r_n_bad <= sat_inc(r_n_bad);
                        end else begin
                            r_state    <= ST_ISSUE;
                            r_dc_done  <= 1'b0;
                            r_ic_done  <= 1'b0;
                            r_tgt_dc   <= (w_route == RT_DC) || (w_route == RT_BOTH);
                            r_tgt_ic   <= (w_route == RT_IC) || (w_route == RT_BOTH);
                            r_dc_req   <= (w_route == RT_DC) || (w_route == RT_BOTH);
                            r_ic_req   <= (w_route == RT_IC) || (w_route == RT_BOTH);
                            r_op       <= w_head_op;
                            r_offset   <= w_head_addr[OFFSET_W-1:0];
                            r_dc_index <= w_head_addr[OFFSET_W+DC_INDEX_W-1:OFFSET_W];
                            r_dc_tag   <= w_head_addr[ADDR_W-1:OFFSET_W+DC_INDEX_W];
                            r_ic_index <= w_head_addr[OFFSET_W+IC_INDEX_W-1:OFFSET_W];
                            r_ic_tag   <= w_head_addr[ADDR_W-1:OFFSET_W+IC_INDEX_W];
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_dc_req && bus.dc_ack) begin
                        r_dc_req  <= 1'b0;
                        r_dc_done <= 1'b1;
                    end
                    if (r_ic_req && bus.ic_ack) begin
                        r_ic_req  <= 1'b0;
                        r_ic_done <= 1'b1;
                    end
                    if (w_complete) begin
                        r_state  <= ST_IDLE;
                        r_dc_req <= 1'b0;
                        r_ic_req <= 1'b0;
                        if (r_op == OP_CLEAR) begin
                            r_n_disp <= '0;
                            r_n_bad  <= '0;
                        end else begin
                            r_n_disp <= sat_inc(r_n_disp);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dc_req    = r_dc_req;
    assign bus.dc_op     = r_op;
    assign bus.dc_tag    = r_dc_tag;
    assign bus.dc_index  = r_dc_index;
    assign bus.dc_offset = r_offset;
    assign bus.ic_req    = r_ic_req;
    assign bus.ic_op     = r_op;
    assign bus.ic_tag    = r_ic_tag;
    assign bus.ic_index  = r_ic_index;
    assign bus.ic_offset = r_offset;
    assign n_dispatched  = r_n_disp;
    assign n_bad_op      = r_n_bad;

endmodule

// File: tb/tb_trace_dispatch.sv
// Directed bench for trace_dispatch: routing, address split, FIFO flow, counters, reset.
module tb_trace_dispatch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] n_disp;
    logic [31:0] n_bad;
    int          checks = 0;
    int          errors = 0;

    trace_dispatch_if u_if ();

    trace_dispatch u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (u_if),
        .n_dispatched (n_disp),
        .n_bad_op     (n_bad)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_op = 4'd0;
        u_if.in_addr = 32'd0;
        u_if.dc_ack = 1'b0;
        u_if.ic_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Presents one command for one cycle; returns on the negedge after it was accepted
    task automatic push(input logic [3:0] op, input logic [31:0] addr);
        u_if.in_valid = 1'b1;
        u_if.in_op = op;
        u_if.in_addr = addr;
        @(negedge clk);
        u_if.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_in_ready", u_if.in_ready, 1);
        chk("rst_dc_req", u_if.dc_req, 0);
        chk("rst_ic_req", u_if.ic_req, 0);
        chk("rst_n_disp", n_disp, 0);
        chk("rst_n_bad", n_bad, 0);
        chk("rst_dc_tag", u_if.dc_tag, 0);

        // Op 0 read, ack two cycles after req rises
        push(4'd0, 32'h1234_5678);
        chk("t1_no_req_yet", u_if.dc_req, 0);
        @(negedge clk);
        chk("t1_dc_req", u_if.dc_req, 1);
        chk("t1_dc_tag", u_if.dc_tag, 12'h123);
        chk("t1_dc_index", u_if.dc_index, 14'h1159);
        chk("t1_dc_offset", u_if.dc_offset, 6'h38);
        chk("t1_dc_op", u_if.dc_op, 0);
        chk("t1_ic_req0", u_if.ic_req, 0);
        @(negedge clk);
        chk("t1_dc_req_p1", u_if.dc_req, 1);
        chk("t1_ic_req1", u_if.ic_req, 0);
        @(negedge clk);
        chk("t1_dc_req_p2", u_if.dc_req, 1);
        u_if.dc_ack = 1'b1;
        @(negedge clk);
        u_if.dc_ack = 1'b0;
        chk("t1_dc_req_drop", u_if.dc_req, 0);
        chk("t1_ic_req2", u_if.ic_req, 0);
        chk("t1_n_disp", n_disp, 1);

        // Op 2 fetch with ic_ack held high
        do_reset();
        u_if.ic_ack = 1'b1;
        push(4'd2, 32'h0000_0040);
        @(negedge clk);
        chk("t2_ic_req", u_if.ic_req, 1);
        chk("t2_ic_index", u_if.ic_index, 14'h0001);
        chk("t2_ic_offset", u_if.ic_offset, 0);
        chk("t2_ic_tag", u_if.ic_tag, 0);
        chk("t2_dc_req", u_if.dc_req, 0);
        @(negedge clk);
        chk("t2_ic_req_1cyc", u_if.ic_req, 0);
        chk("t2_n_disp", n_disp, 1);
        u_if.ic_ack = 1'b0;

        // Op 3 broadcast, dc acks at +1, ic at +4
        do_reset();
        push(4'd3, 32'hABCD_EF01);
        @(negedge clk);
        chk("t3_dc_req0", u_if.dc_req, 1);
        chk("t3_ic_req0", u_if.ic_req, 1);
        chk("t3_ic_op", u_if.ic_op, 3);
        @(negedge clk);
        u_if.dc_ack = 1'b1;
        @(negedge clk);
        u_if.dc_ack = 1'b0;
        chk("t3_dc_req2", u_if.dc_req, 0);
        chk("t3_ic_req2", u_if.ic_req, 1);
        chk("t3_n_disp2", n_disp, 0);
        @(negedge clk);
        chk("t3_ic_req3", u_if.ic_req, 1);
        @(negedge clk);
        chk("t3_ic_req4", u_if.ic_req, 1);
        u_if.ic_ack = 1'b1;
        @(negedge clk);
        u_if.ic_ack = 1'b0;
        chk("t3_ic_req5", u_if.ic_req, 0);
        chk("t3_n_disp", n_disp, 1);
        @(negedge clk);
        @(negedge clk);
        chk("t3_single_pop_dc", u_if.dc_req, 0);
        chk("t3_single_pop_ic", u_if.ic_req, 0);
        chk("t3_n_disp_hold", n_disp, 1);

        // Illegal op 6 followed by op 1
        do_reset();
        u_if.in_valid = 1'b1;
        u_if.in_op = 4'd6;
        u_if.in_addr = 32'h0000_1000;
        @(negedge clk);
        u_if.in_op = 4'd1;
        u_if.in_addr = 32'h0000_2080;
        @(negedge clk);
        u_if.in_valid = 1'b0;
        chk("t4_no_req_bad", u_if.dc_req | u_if.ic_req, 0);
        chk("t4_n_bad", n_bad, 1);
        @(negedge clk);
        chk("t4_dc_req", u_if.dc_req, 1);
        chk("t4_dc_op", u_if.dc_op, 1);
        chk("t4_dc_index", u_if.dc_index, 14'h0082);
        u_if.dc_ack = 1'b1;
        @(negedge clk);
        u_if.dc_ack = 1'b0;
        chk("t4_n_disp", n_disp, 1);
        chk("t4_n_bad_hold", n_bad, 1);

        // Three pushes with acks withheld
        do_reset();
        u_if.in_valid = 1'b1;
        u_if.in_op = 4'd0;
        u_if.in_addr = 32'h0000_0100;
        @(negedge clk);
        chk("t5_ready_1", u_if.in_ready, 1);
        u_if.in_addr = 32'h0000_0200;
        @(negedge clk);
        chk("t5_full", u_if.in_ready, 0);
        chk("t5_req_a", u_if.dc_req, 1);
        chk("t5_idx_a", u_if.dc_index, 14'h0004);
        u_if.in_addr = 32'h0000_0300;
        @(negedge clk);
        chk("t5_full_hold", u_if.in_ready, 0);
        @(negedge clk);
        chk("t5_full_hold2", u_if.in_ready, 0);
        u_if.dc_ack = 1'b1;
        @(negedge clk);
        u_if.dc_ack = 1'b0;
        chk("t5_ready_after_pop", u_if.in_ready, 1);
        chk("t5_gap", u_if.dc_req, 0);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        chk("t5_third_taken", u_if.in_ready, 0);
        chk("t5_req_b", u_if.dc_req, 1);
        chk("t5_idx_b", u_if.dc_index, 14'h0008);
        u_if.dc_ack = 1'b1;
        @(negedge clk);
        u_if.dc_ack = 1'b0;
        chk("t5_n_disp2", n_disp, 2);
        @(negedge clk);
        chk("t5_req_c", u_if.dc_req, 1);
        chk("t5_idx_c", u_if.dc_index, 14'h000C);
        u_if.dc_ack = 1'b1;
        @(negedge clk);
        u_if.dc_ack = 1'b0;
        chk("t5_n_disp3", n_disp, 3);
        chk("t5_empty", u_if.in_ready, 1);

        // Five dispatches plus one illegal op, then op 8 clears both counters
        do_reset();
        u_if.dc_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(4'd0, 32'h0000_0040 * i);
            @(negedge clk);
            @(negedge clk);
        end
        chk("t6_n_disp5", n_disp, 5);
        push(4'd15, 32'h0);
        @(negedge clk);
        chk("t6_n_bad1", n_bad, 1);
        u_if.ic_ack = 1'b1;
        push(4'd8, 32'h0);
        @(negedge clk);
        chk("t6_clr_dc_req", u_if.dc_req, 1);
        chk("t6_clr_ic_req", u_if.ic_req, 1);
        @(negedge clk);
        chk("t6_clr_n_disp", n_disp, 0);
        chk("t6_clr_n_bad", n_bad, 0);
        u_if.dc_ack = 1'b0;
        u_if.ic_ack = 1'b0;

        // Reset while a broadcast is in flight and another command is buffered
        push(4'd3, 32'h0000_1000);
        push(4'd0, 32'h0000_2000);
        chk("t7_issue_dc", u_if.dc_req, 1);
        chk("t7_issue_ic", u_if.ic_req, 1);
        chk("t7_full", u_if.in_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_async_dc", u_if.dc_req, 0);
        chk("t7_async_ic", u_if.ic_req, 0);
        chk("t7_async_ready", u_if.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t7_discard_dc", u_if.dc_req, 0);
        chk("t7_discard_ic", u_if.ic_req, 0);
        chk("t7_n_disp", n_disp, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
